freeway_game_ctrl: RTL and testbench
====================================

# freeway_game_ctrl

Game sequencer for the Freeway-style VGA game. It owns the chicken's lane position, score, lives and round timer, and tells the renderer whether cars advance. Chicken/car collision is sampled once per frame. It sits between the board buttons and the render block: it drives `chicken_row`, `cars_run` and `flash`, and receives `collision` back.

## Interface
Parameters:
- `LANES`, 7: number of lane steps from the start row (lane 0) to the goal (lane `LANES`).
- `LIVES`, 3: lives per game, 1..3.
- `FPS`, 60: frame ticks per second.
- `ROUND_SECONDS`, 90: round length in seconds, 1..127.
- `HIT_FRAMES`, 48: freeze length after a hit, in frames.

Ports (reset is synchronous, active-high; clock is `clk`):
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `frame_tick` in 1: one-cycle pulse per frame, at vertical-blank start.
- `btn_up` in 1: synchronized button level.
- `btn_down` in 1: synchronized button level.
- `collision` in 1: chicken/car overlap from the renderer.
- `state` out 3: current FSM state.
- `chicken_lane` out 3: 0..`LANES`.
- `chicken_row` out 10: 435 − 60·`chicken_lane`.
- `cars_run` out 1: enables car movement.
- `flash` out 1: chicken blink during a hit; the renderer hides the chicken while it is 1.
- `score` out 8: two BCD digits, 00..99.
- `lives` out 2: lives remaining.
- `time_left` out 7: seconds remaining.
- `game_over` out 1: high in OVER.

## Operation
- **Button capture.** A rising edge of `btn_up` sets `pend_up`; a rising edge of `btn_down` sets `pend_dn`. Edges are detected on `clk`. Both pending flags clear on every `frame_tick` and on every state change.
- **Lane move.** If both flags are set at a tick, neither move is applied.
- **State IDLE.**
  - Lane 0, `cars_run`=0.
  - A `pend_up` at a tick moves to PLAY and loads score=0, lives=`LIVES`, `time_left`=`ROUND_SECONDS`, and the frame counter to 0.
- **State PLAY.** `cars_run`=1. At each tick, the first matching case below applies:
  1. Frame counter equals `FPS`−1 and `time_left`=1: `time_left` becomes 0, go to OVER. The timer takes priority over a collision on the same tick.
  2. `collision`=1: lives decrement, go to HIT, move dropped.
  3. Up move: lane+1. If the new lane equals `LANES`, score increments in BCD (saturating at 99) and the lane returns to 0 in the same update.
  4. Down move: lane−1, saturating at 0.
  - On every PLAY tick the frame counter increments. When it wraps from `FPS`−1 to 0, `time_left` decrements.
- **State HIT.**
  - `cars_run`=0, timer paused, moves ignored.
  - A hit counter counts ticks from 0. `flash` = bit 3 of the hit counter.
  - At count `HIT_FRAMES`−1: if lives=0 go to OVER; else lane=0, `flash`=0, go to PLAY.
- **State OVER.**
  - `game_over`=1, `cars_run`=0, lane 0.
  - A `pend_up` at a tick moves to IDLE. Score is held until the next start.
- **Encoding.** IDLE=0, PLAY=1, HIT=2, OVER=3.

## Timing
- All outputs are registered. A tick at cycle N updates the outputs at cycle N+1.
- `chicken_row` is registered alongside `chicken_lane`, so it is valid in the same cycle.
- `collision` is sampled only in the cycle where `frame_tick`=1. Its value between ticks is ignored.
- A button edge in the same cycle as `frame_tick` is not applied at that tick. It is held for the next tick only if no state change occurred.
- `frame_tick` asserted in consecutive cycles is treated as separate ticks.
- Values after `reset`:
  - state=IDLE, lane=0, `chicken_row`=435.
  - score=0, lives=`LIVES`, `time_left`=`ROUND_SECONDS`.
  - `cars_run`=0, `flash`=0, `game_over`=0.
  - Pending flags, edge registers and all counters cleared.
- `reset` in the middle of a game takes priority over everything, including a simultaneous tick.

## Structure
- **Package `freeway_pkg`:**
  - State enumeration.
  - `LANE_PITCH`=60 and `START_ROW`=435.
  - The 640×480 screen constants.
- **Sub-module `btn_edge_latch`:** edge detector plus pending flag, with a clear input. Instantiated twice.

## Test plan
- **Reset:** reset, then 3 ticks with no input -> IDLE, lane 0, `chicken_row`=435, lives=3, `time_left`=90, `cars_run`=0.
- **Scoring:** start, then 7 up-presses at 7 ticks -> score 0x01, lane 0 after the 7th tick; one further down-press at lane 0 -> lane stays 0.
- **Hit:** at lane 3, `collision`=1 at a tick -> HIT, lives=2, `cars_run`=0; `flash` toggles every 8 ticks; after 48 ticks -> PLAY, lane 0, `time_left` unchanged.
- **Last life:** three collisions -> OVER after the third hit period, `game_over`=1; up-press -> IDLE, score retained.
- **Timer:** `ROUND_SECONDS`=2, `FPS`=4 -> OVER after 8 PLAY ticks. Assert `collision` on the 8th tick -> still OVER with lives unchanged.
- **Cancellation:** up and down pressed before the same tick -> lane unchanged. A press in the same cycle as `frame_tick` -> applied at the next tick.

Source files
------------

// File: rtl/freeway_pkg.sv
// rtl/freeway_pkg.sv - shared types, screen geometry and helpers for the Freeway game block
package freeway_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PLAY = 3'd1,
    HIT  = 3'd2,
    OVER = 3'd3
  } state_t;

  localparam int LANE_PITCH = 60;
  localparam int START_ROW  = 435;
  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;

  function automatic logic [9:0] lane_row(input logic [2:0] lane);
    return 10'(START_ROW - LANE_PITCH * int'(lane));
  endfunction

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99) return v;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/freeway_game_ctrl_btn_edge_latch.sv
// rtl/freeway_game_ctrl_btn_edge_latch.sv - rising-edge detector with a pending flag
module btn_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic clear,
  input  logic flush,
  output logic pend
);

  logic prev;

  // clear drops the flag seen at this tick but keeps an edge arriving in the
  // same cycle; flush (state change) drops everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= 1'b0;
      pend <= 1'b0;
    end else begin
      prev <= btn;
      if (flush) pend <= 1'b0;
      else       pend <= (btn & ~prev) | (pend & ~clear);
    end
  end

endmodule

// File: rtl/freeway_game_ctrl.sv
// rtl/freeway_game_ctrl.sv - Freeway game sequencer: lane, score, lives, round timer, hit freeze
import freeway_pkg::*;

module freeway_game_ctrl #(
  parameter int LANES         = 7,
  parameter int LIVES         = 3,
  parameter int FPS           = 60,
  parameter int ROUND_SECONDS = 90,
  parameter int HIT_FRAMES    = 48
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       collision,
  output logic [2:0] state,
  output logic [2:0] chicken_lane,
  output logic [9:0] chicken_row,
  output logic       cars_run,
  output logic       flash,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [6:0] time_left,
  output logic       game_over
);

  state_t     st, st_n;
  logic [2:0] lane_n;
  logic [7:0] score_n, frame_cnt, frame_n, hit_cnt, hit_n;
  logic [1:0] lives_n;
  logic [6:0] time_n;
  logic       pend_up, pend_dn, flush, last_frame, up_mv, dn_mv;

  assign state = st;
  assign flush = frame_tick & (st_n != st);

  btn_edge_latch u_up (
    .clk(clk), .reset(reset), .btn(btn_up), .clear(frame_tick), .flush(flush), .pend(pend_up)
  );
  btn_edge_latch u_dn (
    .clk(clk), .reset(reset), .btn(btn_down), .clear(frame_tick), .flush(flush), .pend(pend_dn)
  );

  always_comb begin
    st_n       = st;
    lane_n     = chicken_lane;
    score_n    = score;
    lives_n    = lives;
    time_n     = time_left;
    frame_n    = frame_cnt;
    hit_n      = hit_cnt;
    last_frame = (frame_cnt == 8'(FPS - 1));
    up_mv      = pend_up & ~pend_dn;
    dn_mv      = pend_dn & ~pend_up;
    if (frame_tick) begin
      case (st)
        IDLE: if (pend_up) begin
          st_n    = PLAY;
          score_n = 8'h00;
          lives_n = 2'(LIVES);
          time_n  = 7'(ROUND_SECONDS);
          frame_n = 8'd0;
        end
        PLAY: begin
          frame_n = last_frame ? 8'd0 : frame_cnt + 8'd1;
          if (last_frame) time_n = time_left - 7'd1;
          // Timer expiry wins over a collision on the same tick.
          if (last_frame && time_left == 7'd1) begin
            st_n   = OVER;
            lane_n = 3'd0;
          end else if (collision) begin
            st_n    = HIT;
            lives_n = lives - 2'd1;
            hit_n   = 8'd0;
          end else if (up_mv) begin
            if (chicken_lane == 3'(LANES - 1)) begin
              lane_n  = 3'd0;
              score_n = bcd_inc(score);
            end else begin
              lane_n = chicken_lane + 3'd1;
            end
          end else if (dn_mv && chicken_lane != 3'd0) begin
            lane_n = chicken_lane - 3'd1;
          end
        end
        HIT: begin
          if (hit_cnt == 8'(HIT_FRAMES - 1)) begin
            lane_n = 3'd0;
            st_n   = (lives == 2'd0) ? OVER : PLAY;
          end else begin
            hit_n = hit_cnt + 8'd1;
          end
        end
        OVER: if (pend_up) st_n = IDLE;
        default: st_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st           <= IDLE;
      chicken_lane <= 3'd0;
      chicken_row  <= 10'(START_ROW);
      score        <= 8'h00;
      lives        <= 2'(LIVES);
      time_left    <= 7'(ROUND_SECONDS);
      frame_cnt    <= 8'd0;
      hit_cnt      <= 8'd0;
      cars_run     <= 1'b0;
      flash        <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      st           <= st_n;
      chicken_lane <= lane_n;
      chicken_row  <= lane_row(lane_n);
      score        <= score_n;
      lives        <= lives_n;
      time_left    <= time_n;
      frame_cnt    <= frame_n;
      hit_cnt      <= hit_n;
      cars_run     <= (st_n == PLAY);
      flash        <= (st_n == HIT) ? hit_n[3] : 1'b0;
      game_over    <= (st_n == OVER);
    end
  end

endmodule

// File: tb/tb_freeway_game_ctrl.sv
// tb/tb_freeway_game_ctrl.sv - directed table-driven bench for freeway_game_ctrl
module tb_freeway_game_ctrl;

  logic clk = 1'b0;
  logic reset, frame_tick, btn_up, btn_down, collision;

  logic [2:0] a_state, a_lane, b_state, b_lane;
  logic [9:0] a_row, b_row;
  logic       a_cars, a_flash, a_over, b_cars, b_flash, b_over;
  logic [7:0] a_score, b_score;
  logic [1:0] a_lives, b_lives;
  logic [6:0] a_time, b_time;

  freeway_game_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_up(btn_up), .btn_down(btn_down),
    .collision(collision), .state(a_state), .chicken_lane(a_lane), .chicken_row(a_row),
    .cars_run(a_cars), .flash(a_flash), .score(a_score), .lives(a_lives), .time_left(a_time),
    .game_over(a_over)
  );

  freeway_game_ctrl #(.FPS(4), .ROUND_SECONDS(2)) dut_tmr (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_up(btn_up), .btn_down(btn_down),
    .collision(collision), .state(b_state), .chicken_lane(b_lane), .chicken_row(b_row),
    .cars_run(b_cars), .flash(b_flash), .score(b_score), .lives(b_lives), .time_left(b_time),
    .game_over(b_over)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       up, dn, col;
    logic [2:0] st;
    logic [2:0] lane;
    logic [7:0] score;
    logic [1:0] lives;
    logic       cars;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic u, input logic d);
    btn_up = u; btn_down = d;
    cyc();
    btn_up = 1'b0; btn_down = 1'b0;
    cyc();
  endtask

  task automatic tick(input logic c);
    frame_tick = 1'b1; collision = c;
    cyc();
    frame_tick = 1'b0; collision = 1'b0;
  endtask

  task automatic step(input logic u, input logic d, input logic c);
    press(u, d);
    tick(c);
  endtask

  task automatic hit_period(input string tag);
    for (int k = 1; k <= 48; k++) begin
      tick(1'b0);
      if (k == 47) chk({tag, "_still_hit"}, a_state, 2);
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 3'd1, 3'd0, 8'h00, 2'd3, 1'b1};
    for (int i = 1; i <= 6; i++)
      tbl[i] = '{1'b1, 1'b0, 1'b0, 3'd1, 3'(i), 8'h00, 2'd3, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 3'd1, 3'd0, 8'h01, 2'd3, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 3'd1, 3'd0, 8'h01, 2'd3, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 3'd1, 3'd1, 8'h01, 2'd3, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 3'd1, 3'd2, 8'h01, 2'd3, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 3'd1, 3'd3, 8'h01, 2'd3, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 3'd1, 3'd3, 8'h01, 2'd3, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 3'd2, 3'd3, 8'h01, 2'd2, 1'b0};

    reset = 1'b1; frame_tick = 1'b0; btn_up = 1'b0; btn_down = 1'b0; collision = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    chk("rst_state", a_state, 0);
    chk("rst_row", a_row, 435);
    chk("rst_score", a_score, 0);
    chk("rst_flash", a_flash, 0);
    chk("rst_over", a_over, 0);
    for (int i = 0; i < 3; i++) tick(1'b0);
    chk("idle_state", a_state, 0);
    chk("idle_lane", a_lane, 0);
    chk("idle_row", a_row, 435);
    chk("idle_lives", a_lives, 3);
    chk("idle_time", a_time, 90);
    chk("idle_cars", a_cars, 0);

    // Short-round instance: 2 s at 4 fps expires on the 8th PLAY tick.
    step(1'b1, 1'b0, 1'b0);
    chk("tmr_start", b_state, 1);
    chk("tmr_time0", b_time, 2);
    for (int i = 1; i <= 7; i++) tick(1'b0);
    chk("tmr_play7", b_state, 1);
    chk("tmr_time7", b_time, 1);
    tick(1'b1);
    chk("tmr_over", b_state, 3);
    chk("tmr_lives", b_lives, 3);
    chk("tmr_time8", b_time, 0);
    chk("tmr_gameover", b_over, 1);
    chk("tmr_cars", b_cars, 0);

    reset = 1'b1; cyc(); reset = 1'b0; cyc();

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].up, tbl[i].dn, tbl[i].col);
      chk($sformatf("v%0d_state", i), a_state, 32'(tbl[i].st));
      chk($sformatf("v%0d_lane", i), a_lane, 32'(tbl[i].lane));
      chk($sformatf("v%0d_row", i), a_row, 435 - 60 * int'(tbl[i].lane));
      chk($sformatf("v%0d_score", i), a_score, 32'(tbl[i].score));
      chk($sformatf("v%0d_lives", i), a_lives, 32'(tbl[i].lives));
      chk($sformatf("v%0d_cars", i), a_cars, 32'(tbl[i].cars));
    end

    // Hit freeze: flash follows bit 3 of the tick count, moves ignored.
    for (int k = 1; k <= 48; k++) begin
      if (k == 20) press(1'b1, 1'b0);
      tick(1'b0);
      if (k == 7)  chk("hit_flash7", a_flash, 0);
      if (k == 8)  chk("hit_flash8", a_flash, 1);
      if (k == 16) chk("hit_flash16", a_flash, 0);
      if (k == 20) chk("hit_lane_frozen", a_lane, 3);
      if (k == 24) chk("hit_flash24", a_flash, 1);
      if (k == 47) chk("hit_state47", a_state, 2);
    end
    chk("hit_exit_state", a_state, 1);
    chk("hit_exit_lane", a_lane, 0);
    chk("hit_exit_row", a_row, 435);
    chk("hit_exit_flash", a_flash, 0);
    chk("hit_exit_time", a_time, 90);
    chk("hit_exit_cars", a_cars, 1);

    step(1'b0, 1'b0, 1'b1);
    chk("hit2_lives", a_lives, 1);
    hit_period("hit2");
    chk("hit2_exit", a_state, 1);
    step(1'b0, 1'b0, 1'b1);
    chk("hit3_lives", a_lives, 0);
    hit_period("hit3");
    chk("last_state", a_state, 3);
    chk("last_gameover", a_over, 1);
    chk("last_lane", a_lane, 0);
    chk("last_cars", a_cars, 0);
    chk("last_score", a_score, 1);
    step(1'b1, 1'b0, 1'b0);
    chk("over_idle", a_state, 0);
    chk("over_score_held", a_score, 1);
    chk("over_gameover_low", a_over, 0);

    // Press in the tick cycle is not applied there but carries to the next tick.
    btn_up = 1'b1; frame_tick = 1'b1;
    cyc();
    btn_up = 1'b0; frame_tick = 1'b0;
    cyc();
    chk("same_cycle_idle", a_state, 0);
    tick(1'b0);
    chk("next_tick_play", a_state, 1);
    chk("restart_score", a_score, 0);
    chk("restart_lives", a_lives, 3);
    chk("restart_time", a_time, 90);

    // Back-to-back ticks: the second has no pending move.
    btn_up = 1'b1; cyc(); btn_up = 1'b0;
    frame_tick = 1'b1; cyc(); cyc(); frame_tick = 1'b0;
    chk("b2b_lane", a_lane, 1);

    reset = 1'b1; frame_tick = 1'b1;
    cyc();
    reset = 1'b0; frame_tick = 1'b0;
    chk("midreset_state", a_state, 0);
    chk("midreset_lane", a_lane, 0);
    chk("midreset_cars", a_cars, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
